// File: rtl/uart_loader.sv
// Boot loader: receives a little-endian word count then that many words over UART and writes them to memory.
// Optional checksum trailer byte is enabled with `define LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        start,
  output logic [31:0] uart_data,
  output logic [31:0] uart_addr,
  output logic        uart_we,
  output logic        uart_done,
  output logic        load_err
);

  localparam logic [31:0 ] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [31:0] idx_q;
  logic [31:0] len_q;
  logic [31:0] word;
  logic        accept;
  logic        len_load;
  logic        wr_en;

  // The current byte completes the word combinationally, so the write can be registered on the same edge.
  assign word = {rx_data, asm_q};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_upd;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_LEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    len_load = 1'b0;
    wr_en    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_upd = 1'b0;
`endif
    if (start) begin
      state_d = S_LEN;
    end else begin
      case (state_q)
        S_LEN: begin
          if (rx_valid) begin
            accept = 1'b1;
            if (byte_cnt == 2'd3) begin
              len_load = 1'b1;
              if (word == 32'd0)      state_d = S_DONE;
              else if (word > MAX_W)  state_d = S_ERR;
              else                    state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            accept = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_upd = 1'b1;
`endif
            if (byte_cnt == 2'd3) begin
              wr_en = 1'b1;
              if (idx_q == len_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            accept  = 1'b1;
            state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt  <= 2'd0;
      asm_q     <= 24'd0;
      idx_q     <= 32'd0;
      len_q     <= 32'd0;
      uart_data <= 32'd0;
      uart_addr <= BASE_ADDR;
      uart_we   <= 1'b0;
      uart_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      uart_we   <= wr_en;
      uart_done <= !start && (state_q == S_DONE);
      if (start) begin
        byte_cnt <= 2'd0;
        idx_q    <= 32'd0;
        load_err <= 1'b0;
      end else begin
        if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= word[31:8];
        end
        if (len_load) len_q <= word;
        if (wr_en) begin
          uart_data <= word;
          uart_addr <= BASE_ADDR + {idx_q[29:0], 2'b00};
          idx_q     <= idx_q + 32'd1;
        end
        if (state_d == S_ERR) load_err <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n || start) csum_q <= 8'd0;
    else if (csum_upd)   csum_q <= csum_q ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: count/data framing, limits, reset and restart behaviour.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        start;
  logic [31:0] uart_data;
  logic [31:0] uart_addr;
  logic        uart_we;
  logic        uart_done;
  logic        load_err;

  int vecs = 0;
  int errs = 0;
  int we_count = 0;
  int wc;

  uart_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .start(start),
    .uart_data(uart_data), .uart_addr(uart_addr), .uart_we(uart_we),
    .uart_done(uart_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (uart_we === 1'b1) we_count++;

  // All tasks are entered and left at a falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_load(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    send(c);
`else
    rx_data = c;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vecs++; if (uart_we !== 1'b0) begin errs++; $display("FAIL rst_we got %b want 0", uart_we); end
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", uart_done); end
    vecs++; if (load_err !== 1'b0) begin errs++; $display("FAIL rst_err got %b want 0", load_err); end
    vecs++; if (uart_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", uart_addr); end
    vecs++; if (uart_data !== 32'h0) begin errs++; $display("FAIL rst_data got %h want 0", uart_data); end
  endtask

  task automatic test_two_words();
    send_word(32'h2);
    send_word(32'h13);
    vecs++; if (uart_we !== 1'b1) begin errs++; $display("FAIL w0_we got %b want 1", uart_we); end
    vecs++; if (uart_addr !== 32'h0) begin errs++; $display("FAIL w0_addr got %h want 00000000", uart_addr); end
    vecs++; if (uart_data !== 32'h13) begin errs++; $display("FAIL w0_data got %h want 00000013", uart_data); end
    send_word(32'h0010_0093);
    vecs++; if (uart_we !== 1'b1) begin errs++; $display("FAIL w1_we got %b want 1", uart_we); end
    vecs++; if (uart_addr !== 32'h4) begin errs++; $display("FAIL w1_addr got %h want 00000004", uart_addr); end
    vecs++; if (uart_data !== 32'h0010_0093) begin errs++; $display("FAIL w1_data got %h want 00100093", uart_data); end
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL w1_done_early got %b want 0", uart_done); end
    finish_load(8'h90);
    @(negedge clk);
    vecs++; if (uart_done !== 1'b1) begin errs++; $display("FAIL two_done got %b want 1", uart_done); end
    vecs++; if (uart_we !== 1'b0) begin errs++; $display("FAIL we_pulse got %b want 0", uart_we); end
    vecs++; if (uart_data !== 32'h0010_0093) begin errs++; $display("FAIL data_hold got %h want 00100093", uart_data); end
    wc = we_count;
    send(8'h55);
    repeat (2) @(negedge clk);
    vecs++; if (we_count !== wc) begin errs++; $display("FAIL done_ignore_rx got %0d writes want %0d", we_count, wc); end
    vecs++; if (uart_done !== 1'b1) begin errs++; $display("FAIL done_sticky got %b want 1", uart_done); end
  endtask

  task automatic test_zero_count();
    pulse_start();
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL start_clr_done got %b want 0", uart_done); end
    wc = we_count;
    send_word(32'h0);
    @(negedge clk);
    vecs++; if (uart_done !== 1'b1) begin errs++; $display("FAIL zero_done got %b want 1", uart_done); end
    repeat (2) @(negedge clk);
    vecs++; if (we_count !== wc) begin errs++; $display("FAIL zero_no_we got %0d writes want %0d", we_count, wc); end
  endtask

  task automatic test_too_big();
    pulse_start();
    wc = we_count;
    send_word(32'h0000_4001);
    vecs++; if (load_err !== 1'b1) begin errs++; $display("FAIL big_err got %b want 1", load_err); end
    repeat (3) @(negedge clk);
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL big_done got %b want 0", uart_done); end
    vecs++; if (load_err !== 1'b1) begin errs++; $display("FAIL big_err_sticky got %b want 1", load_err); end
    vecs++; if (we_count !== wc) begin errs++; $display("FAIL big_no_we got %0d writes want %0d", we_count, wc); end
  endtask

  task automatic test_max_boundary();
    pulse_start();
    vecs++; if (load_err !== 1'b0) begin errs++; $display("FAIL start_clr_err got %b want 0", load_err); end
    send_word(32'h0000_4000);
    repeat (2) @(negedge clk);
    vecs++; if (load_err !== 1'b0) begin errs++; $display("FAIL max_ok_err got %b want 0", load_err); end
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL max_ok_done got %b want 0", uart_done); end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h11); send(8'h22);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vecs++; if (uart_data !== 32'h0) begin errs++; $display("FAIL mid_rst_data got %h want 0", uart_data); end
    send_word(32'h1);
    send_word(32'hDDCC_BBAA);
    vecs++; if (uart_we !== 1'b1) begin errs++; $display("FAIL mid_we got %b want 1", uart_we); end
    vecs++; if (uart_addr !== 32'h0) begin errs++; $display("FAIL mid_addr got %h want 00000000", uart_addr); end
    vecs++; if (uart_data !== 32'hDDCC_BBAA) begin errs++; $display("FAIL mid_data got %h want ddccbbaa", uart_data); end
    finish_load(8'h00);
    @(negedge clk);
    vecs++; if (uart_done !== 1'b1) begin errs++; $display("FAIL mid_done got %b want 1", uart_done); end
  endtask

  task automatic test_start_in_done();
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL sd_done got %b want 0", uart_done); end
    send_word(32'h1);
    send_word(32'h1234_5678);
    vecs++; if (uart_we !== 1'b1) begin errs++; $display("FAIL sd_we got %b want 1", uart_we); end
    vecs++; if (uart_addr !== 32'h0) begin errs++; $display("FAIL sd_addr got %h want 00000000", uart_addr); end
    vecs++; if (uart_data !== 32'h1234_5678) begin errs++; $display("FAIL sd_data got %h want 12345678", uart_data); end
    finish_load(8'h08);
    @(negedge clk);
    vecs++; if (uart_done !== 1'b1) begin errs++; $display("FAIL sd_reload_done got %b want 1", uart_done); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_word(32'h1);
    send_word(32'h0403_0201);
    send(8'h04);
    @(negedge clk);
    vecs++; if (uart_done !== 1'b1) begin errs++; $display("FAIL csum_ok_done got %b want 1", uart_done); end
    vecs++; if (load_err !== 1'b0) begin errs++; $display("FAIL csum_ok_err got %b want 0", load_err); end
    pulse_start();
    send_word(32'h1);
    send_word(32'h0403_0201);
    send(8'h05);
    vecs++; if (load_err !== 1'b1) begin errs++; $display("FAIL csum_bad_err got %b want 1", load_err); end
    @(negedge clk);
    vecs++; if (uart_done !== 1'b0) begin errs++; $display("FAIL csum_bad_done got %b want 0", uart_done); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_two_words();
    test_zero_count();
    test_too_big();
    test_max_boundary();
    test_reset_midload();
    test_start_in_done();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
